// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the regfile_pc block and its pc_unit sub-module:
//   default geometry, the PC step, PC/LR index derivation, the PC source
//   encoding used by the PC priority mux, and a byte-lane merge helper.
package regfile_pkg;

  // Default geometry: 16 registers of 32 bits, last two are LR and PC.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;

  // Sequential fetch advances by one 32-bit instruction word.
  localparam int PC_STEP = 4;

  // Widest datapath the merge helper supports. Callers zero-extend into it
  // and truncate the result back to their own width.
  localparam int MERGE_W = 256;

  // Which source the PC takes on the next edge, in priority order.
  typedef enum logic [1:0] {
    PC_SRC_HOLD   = 2'd0,
    PC_SRC_STEP   = 2'd1,
    PC_SRC_WRITE  = 2'd2,
    PC_SRC_BRANCH = 2'd3
  } pc_src_e;

  // The PC is always the highest-numbered register.
  function automatic int pc_index(input int nregs);
    return nregs - 1;
  endfunction

  // The link register sits just below the PC.
  function automatic int lr_index(input int nregs);
    return nregs - 2;
  endfunction

  // Replace the bytes of old_val selected by lane_en with those of new_val.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_val,
    input logic [MERGE_W-1:0]   new_val,
    input logic [MERGE_W/8-1:0] lane_en
  );
    logic [MERGE_W-1:0] res;
    res = old_val;
    for (int b = 0; b < MERGE_W / 8; b++) begin
      if (lane_en[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_pc_pc_unit.sv
// pc_unit
//   Program counter register with its update priority mux and the +4 link
//   value used by branch-and-link.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, PC <- RESET_PC
//   adv    in   advance PC by one word (0 = fetch stall)
//   ib     in   take branch to bv this cycle (highest priority)
//   bv     in   branch target, low two bits ignored
//   pc_wr  in   full-width architectural write to the PC register
//   pc_wd  in   data for pc_wr, low two bits ignored
//   pc     out  current PC (registered, no combinational path from inputs)
//   link   out  current PC + 4, the return address for branch-and-link
module pc_unit
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              ib,
  input  logic [DATA_W-1:0] bv,
  input  logic              pc_wr,
  input  logic [DATA_W-1:0] pc_wd,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] link
);

  localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);
  localparam logic [DATA_W-1:0] STEP       = DATA_W'(PC_STEP);

  pc_src_e           src;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] pc_next;

  // Branch beats an explicit PC write, which beats sequential advance.
  always_comb begin
    src = PC_SRC_HOLD;
    if (ib) begin
      src = PC_SRC_BRANCH;
    end else if (pc_wr) begin
      src = PC_SRC_WRITE;
    end else if (adv) begin
      src = PC_SRC_STEP;
    end
  end

  // Targets are forced word-aligned; the increment wraps modulo 2^DATA_W.
  always_comb begin
    pc_next = pc_reg;
    case (src)
      PC_SRC_BRANCH: pc_next = bv & ALIGN_MASK;
      PC_SRC_WRITE:  pc_next = pc_wd & ALIGN_MASK;
      PC_SRC_STEP:   pc_next = pc_reg + STEP;
      default:       pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc   = pc_reg;
  assign link = pc_reg + STEP;

endmodule

// File: rtl/regfile_pc.sv
// regfile_pc
//   Parametrised CPU register file with an integrated program counter.
//   NREGS-1 general registers (the top one of which is the link register)
//   plus the PC at index NREGS-1. Two registered read ports with write-first
//   bypass, one byte-lane-enabled write port, and hardware link write for
//   branch-and-link.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   ra1, ra2  in   read addresses
//   rd1, rd2  out  registered read data (next-state value of the register;
//                  the PC index returns pre-update PC + PC_READ_OFS)
//   we        in   write enable
//   wa        in   write address
//   wd        in   write data
//   wbe       in   byte-lane enables, bit i covers wd[8i+7:8i]
//   adv       in   PC advance (0 = fetch stall)
//   ib        in   take branch this cycle
//   bv        in   branch target
//   bl        in   branch links (only with ib)
//   iaddr     out  current PC, straight from the PC register
module regfile_pc
  import regfile_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                NREGS       = DEF_NREGS,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] PC_READ_OFS = DATA_W'(8),
  localparam int               AW          = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       ra1,
  input  logic [AW-1:0]       ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                adv,
  input  logic                ib,
  input  logic [DATA_W-1:0]   bv,
  input  logic                bl,
  output logic [DATA_W-1:0]   iaddr
);

  localparam int            PC_IDX  = pc_index(NREGS);
  localparam int            LR_IDX  = lr_index(NREGS);
  localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

  // Only a write covering every lane may redirect the PC; a partial write
  // to the PC index is dropped completely.
  logic pc_wr;
  logic link_en;

  assign pc_wr   = we && (wa == PC_ADDR) && (&wbe);
  assign link_en = ib && bl;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] link_val;

  pc_unit #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .adv   (adv),
    .ib    (ib),
    .bv    (bv),
    .pc_wr (pc_wr),
    .pc_wd (wd),
    .pc    (pc),
    .link  (link_val)
  );

  // Value each register will hold after this edge; this doubles as the
  // read source so a same-cycle write or link is seen by the read ports.
  logic [DATA_W-1:0] read_view [NREGS];

  generate
    for (genvar gi = 0; gi < NREGS - 1; gi++) begin : g_gpr
      localparam bit IS_LR = (gi == LR_IDX);

      logic              hit;
      logic [DATA_W-1:0] q_reg;
      logic [DATA_W-1:0] q_next;

      assign hit = we && (wa == AW'(gi));

      // Link wins over any writeback to LR in the same cycle, all lanes.
      always_comb begin
        q_next = q_reg;
        if (hit) begin
          q_next = DATA_W'(byte_merge(MERGE_W'(q_reg), MERGE_W'(wd),
                                      (MERGE_W/8)'(wbe)));
        end
        if (IS_LR && link_en) begin
          q_next = link_val;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q_reg <= '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign read_view[gi] = q_next;
    end
  endgenerate

  // The PC index reads the pre-update PC plus the pipeline offset; a branch
  // or PC write in the same cycle is deliberately not forwarded.
  assign read_view[PC_IDX] = pc + PC_READ_OFS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      rd1 <= read_view[ra1];
      rd2 <= read_view[ra2];
    end
  end

  assign iaddr = pc;

endmodule

// File: tb/tb_regfile_pc.sv
// tb_regfile_pc
//   Directed test of regfile_pc in the default 32-bit/16-register build and
//   in a 16-bit/8-register build, with hand-computed expectations.
module tb_regfile_pc;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // 32-bit, 16-register instance (LR = r14, PC = r15)
  logic [3:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd, bv, iaddr;
  logic [3:0]  wbe;
  logic        we, adv, ib, bl;

  regfile_pc #(
    .DATA_W      (32),
    .NREGS       (16),
    .RESET_PC    (32'h0),
    .PC_READ_OFS (32'h8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .wbe   (wbe),
    .adv   (adv),
    .ib    (ib),
    .bv    (bv),
    .bl    (bl),
    .iaddr (iaddr)
  );

  // 16-bit, 8-register instance (LR = r6, PC = r7)
  logic [2:0]  s_ra1, s_ra2, s_wa;
  logic [15:0] s_rd1, s_rd2, s_wd, s_bv, s_iaddr;
  logic [1:0]  s_wbe;
  logic        s_we, s_adv, s_ib, s_bl;

  regfile_pc #(
    .DATA_W      (16),
    .NREGS       (8),
    .RESET_PC    (16'h0),
    .PC_READ_OFS (16'h8)
  ) dut16 (
    .clk   (clk),
    .reset (reset),
    .ra1   (s_ra1),
    .ra2   (s_ra2),
    .rd1   (s_rd1),
    .rd2   (s_rd2),
    .we    (s_we),
    .wa    (s_wa),
    .wd    (s_wd),
    .wbe   (s_wbe),
    .adv   (s_adv),
    .ib    (s_ib),
    .bv    (s_bv),
    .bl    (s_bl),
    .iaddr (s_iaddr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    we = 0; wa = 0; wd = 0; wbe = 0; adv = 0; ib = 0; bv = 0; bl = 0;
    ra1 = 0; ra2 = 0;
  endtask

  task automatic idle16();
    s_we = 0; s_wa = 0; s_wd = 0; s_wbe = 0; s_adv = 0; s_ib = 0; s_bv = 0;
    s_bl = 0; s_ra1 = 0; s_ra2 = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle32();
    idle16();
    #1;
    check_eq("reset_iaddr", iaddr, 32'h0);
    check_eq("reset_rd1", rd1, 32'h0);
    check_eq("reset_rd2", rd2, 32'h0);
    check_eq("reset16_iaddr", {16'h0, s_iaddr}, 32'h0);
    check_eq("reset16_rd1", {16'h0, s_rd1}, 32'h0);
    step();
    step();
    reset = 1'b1;

    // ---------------- 32-bit build ----------------
    // Sequential fetch and stall
    adv = 1;
    step(); check_eq("fetch_4", iaddr, 32'h4);
    step(); check_eq("fetch_8", iaddr, 32'h8);
    step(); check_eq("fetch_12", iaddr, 32'hC);
    adv = 0; ra1 = 4'd15;
    step();
    check_eq("read_pc_ofs", rd1, 32'd20);
    check_eq("stall_hold", iaddr, 32'hC);
    step(); check_eq("stall_hold2", iaddr, 32'hC);

    // Byte-lane write with same-cycle bypass on both ports
    idle32();
    we = 1; wa = 4'd2; wd = 32'h11223344; wbe = 4'hF;
    step();
    wd = 32'hAABBCCDD; wbe = 4'b0101; ra1 = 4'd2; ra2 = 4'd2;
    step();
    check_eq("bytelane_bypass1", rd1, 32'h11BB33DD);
    check_eq("bytelane_bypass2", rd2, 32'h11BB33DD);
    idle32();
    we = 1; wa = 4'd2; wd = 32'hFFFFFFFF; wbe = 4'h0; ra1 = 4'd2;
    step();
    check_eq("wbe0_noop", rd1, 32'h11BB33DD);

    // Writes to the PC
    idle32();
    we = 1; wa = 4'd15; wd = 32'h43; wbe = 4'hF; ra1 = 4'd15;
    step();
    check_eq("pc_write", iaddr, 32'h40);
    check_eq("pc_read_no_fwd", rd1, 32'd20);
    ib = 1; bv = 32'h80; wd = 32'h40;
    step();
    check_eq("pc_write_vs_branch", iaddr, 32'h80);
    idle32();
    we = 1; wa = 4'd15; wd = 32'h100; wbe = 4'b0111;
    step();
    check_eq("pc_partial_ignored", iaddr, 32'h80);
    wbe = 4'hF;
    step();
    check_eq("pc_set_100", iaddr, 32'h100);

    // Branch-and-link overriding a same-cycle LR writeback
    idle32();
    ib = 1; bl = 1; bv = 32'h203; adv = 1;
    we = 1; wa = 4'd14; wd = 32'h55; wbe = 4'hF;
    ra1 = 4'd14; ra2 = 4'd15;
    step();
    check_eq("bl_iaddr", iaddr, 32'h200);
    check_eq("bl_link_bypass", rd1, 32'h104);
    check_eq("bl_pc_read_pre", rd2, 32'h108);
    idle32();
    ra1 = 4'd14;
    step();
    check_eq("bl_lr_held", rd1, 32'h104);
    bl = 1; we = 1; wa = 4'd14; wd = 32'h77; wbe = 4'hF;
    step();
    check_eq("bl_without_ib_lr", rd1, 32'h77);
    check_eq("bl_without_ib_pc", iaddr, 32'h200);

    // Wrap
    idle32();
    we = 1; wa = 4'd15; wd = 32'hFFFFFFFC; wbe = 4'hF;
    step();
    check_eq("wrap_pre", iaddr, 32'hFFFFFFFC);
    idle32();
    adv = 1;
    step();
    check_eq("wrap_zero", iaddr, 32'h0);

    // Mid-stream asynchronous reset loses the in-flight write
    idle32();
    adv = 1; we = 1; wa = 4'd3; wd = 32'hDEADBEEF; wbe = 4'hF; ra1 = 4'd3;
    step();
    check_eq("r3_written", rd1, 32'hDEADBEEF);
    check_eq("pre_reset_pc", iaddr, 32'h4);
    wd = 32'h12345678;
    reset = 1'b0;
    #1;
    check_eq("async_reset_iaddr", iaddr, 32'h0);
    check_eq("async_reset_rd1", rd1, 32'h0);
    step();
    reset = 1'b1;
    idle32();
    ra1 = 4'd3;
    step();
    check_eq("r3_after_reset", rd1, 32'h0);

    // ---------------- 16-bit / 8-register build ----------------
    idle16();
    s_adv = 1;
    step(); check_eq("s_fetch_4", {16'h0, s_iaddr}, 32'h4);
    step(); check_eq("s_fetch_8", {16'h0, s_iaddr}, 32'h8);
    step(); check_eq("s_fetch_12", {16'h0, s_iaddr}, 32'hC);
    s_adv = 0; s_ra1 = 3'd7;
    step();
    check_eq("s_read_pc_ofs", {16'h0, s_rd1}, 32'd20);
    check_eq("s_stall_hold", {16'h0, s_iaddr}, 32'hC);

    idle16();
    s_we = 1; s_wa = 3'd2; s_wd = 16'h1234; s_wbe = 2'b11;
    step();
    s_wd = 16'hABCD; s_wbe = 2'b01; s_ra1 = 3'd2;
    step();
    check_eq("s_bytelane_bypass", {16'h0, s_rd1}, 32'h12CD);

    idle16();
    s_we = 1; s_wa = 3'd7; s_wd = 16'h40; s_wbe = 2'b11;
    step();
    check_eq("s_pc_write", {16'h0, s_iaddr}, 32'h40);
    s_wd = 16'h100; s_wbe = 2'b10;
    step();
    check_eq("s_pc_partial_ignored", {16'h0, s_iaddr}, 32'h40);
    s_wbe = 2'b11;
    step();

    idle16();
    s_ib = 1; s_bl = 1; s_bv = 16'h203;
    s_we = 1; s_wa = 3'd6; s_wd = 16'h55; s_wbe = 2'b11;
    s_ra1 = 3'd6; s_ra2 = 3'd7;
    step();
    check_eq("s_bl_iaddr", {16'h0, s_iaddr}, 32'h200);
    check_eq("s_bl_link", {16'h0, s_rd1}, 32'h104);
    check_eq("s_bl_pc_read_pre", {16'h0, s_rd2}, 32'h108);

    idle16();
    s_we = 1; s_wa = 3'd7; s_wd = 16'hFFFC; s_wbe = 2'b11;
    step();
    idle16();
    s_adv = 1;
    step();
    check_eq("s_wrap_zero", {16'h0, s_iaddr}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_pc.md
# regfile_pc

Parametrised register file with integrated program counter: the next-generation replacement for the fixed 16×32 CPU register block. It adds the following over the fixed block:
- Configurable data width and register count.
- Asynchronous reset of every register.
- Byte-lane write enables for `ldrb`/`strb`-style writeback.
- Same-cycle write-to-read bypass.
- Branch-and-link that writes the link register in hardware.

It sits between decode (read addresses), writeback (write port) and instruction fetch (`iaddr`).

## Interface
- `DATA_W`, 32, register/PC width; multiple of 8, ≥16
- `NREGS`, 16, architectural registers including PC; power of two, ≥4
- `RESET_PC`, 0, PC value after reset; word-aligned
- `PC_READ_OFS`, 8, offset added when PC index is read
- `AW` (localparam) = `$clog2(NREGS)`; `PC_IDX` = `NREGS-1`; `LR_IDX` = `NREGS-2`

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; asserted when 0
- `ra1`, `ra2`  in  AW  read addresses
- `rd1`, `rd2`  out  DATA_W  registered read data
- `we`  in  1  write enable
- `wa`  in  AW  write address
- `wd`  in  DATA_W  write data
- `wbe`  in  DATA_W/8  byte-lane enables, bit i covers `wd[8i+7:8i]`
- `adv`  in  1  PC advance (0 = fetch stall)
- `ib`  in  1  take branch this cycle
- `bv`  in  DATA_W  branch target
- `bl`  in  1  branch links (meaningful only with `ib`)
- `iaddr`  out  DATA_W  current PC, direct from PC register

## Operation
- **Reset** (`reset`=0, asynchronous):
  - all general registers ← 0
  - PC ← `RESET_PC`
  - `rd1`, `rd2` ← 0
  - held while low; first update on the first rising edge after release
- **PC update per edge, priority order:**
  1. `ib`: PC ← {`bv[DATA_W-1:2]`, 2'b00}
  2. `we` & `wa`==`PC_IDX` & `wbe` all ones: PC ← `wd` with low 2 bits cleared
  3. `adv`: PC ← PC+4, modulo 2^DATA_W (wraps to 0)
  4. otherwise hold
- A partial-`wbe` write to `PC_IDX` is ignored entirely.
- **General write:**
  - when `we` & `wa`≠`PC_IDX`, update only the bytes whose `wbe` bit is set
  - `we` with `wbe`=0 is a no-op
- **Link:**
  - `ib` & `bl`: LR ← `iaddr`+4 (PC before update, plus 4)
  - link overrides any same-cycle `we` to `LR_IDX`, all lanes
  - `bl` without `ib` is ignored
- **Read, registered, one per port:** `rd` ← next-state value of the addressed register (write-first bypass).
  - Byte-merged write data appears on `rd` in the same edge's result.
  - A link value appears the same way.
  - Reading `PC_IDX` returns pre-update PC + `PC_READ_OFS`; it is not bypassed from a branch.
- Both ports may read the same address; either may alias `wa`.

## Timing
- Read latency: 1 cycle (address at edge N → data valid after edge N).
- Write visible to a read issued in the same cycle: yes, via bypass.
- `iaddr` changes only on clock edges or reset; it has no combinational path from inputs.
- Branch: `iaddr` = target after the edge that sampled `ib`; no extra bubble inside the block.
- `adv`=0 with `ib`=1: the branch is still taken.
- Reset asserted mid-operation: immediate clear; any in-flight write is lost.

## Structure
- Shared package `regfile_pkg`:
  - default `DATA_W`/`NREGS`
  - `PC_STEP`=4
  - `PC_IDX`/`LR_IDX` derivation function
  - byte-merge function (old, new, `wbe`)
- Sub-module `pc_unit`: PC register, priority mux, +4 incrementer, link value (`iaddr`+4) output.
- Top: register array (reset-clearable flops, not memory), byte-merge, link override, bypass read mux.

## Test plan
- **Reset** → `iaddr`=`RESET_PC`, `rd1`=`rd2`=0.
  - Pulse `reset` low mid-stream after writing r3=0xDEADBEEF, then read r3 → 0.
- **Byte-lane write:**
  - write r2=0x11223344 (`wbe`=4'hF), then `wd`=0xAABBCCDD with `wbe`=4'b0101 → r2 reads 0x11BB33DD.
  - same-cycle read of r2 during that write → 0x11BB33DD.
- **Sequential fetch:**
  - `adv`=1 from PC=0 for 3 edges → `iaddr` 4, 8, 12.
  - read r15 at PC=12 → 20 (`PC_READ_OFS`=8).
  - `adv`=0 → `iaddr` holds.
- **Branch-and-link:**
  - at PC=0x100, `ib`=`bl`=1, `bv`=0x203, plus `we` to r14 with 0x55 → `iaddr`=0x200, r14=0x104.
- **Write to PC:**
  - `we`, `wa`=15, `wd`=0x40, full `wbe` → `iaddr`=0x40.
  - same with `ib`=1, `bv`=0x80 → `iaddr`=0x80.
  - partial `wbe` → PC unchanged.
- **Wrap:** PC=0xFFFFFFFC, `adv`=1 → `iaddr`=0.
- **Reparametrisation:** `DATA_W`=16, `NREGS`=8 → r6 is LR, r7 is PC, and all scenarios above pass scaled.
